bus_decoder: RTL and testbench

Address decoder and response multiplexer between the core's shared memory bus (arbitrated instruction/data bus) and up to four slave ports (memories or `bus_bridge` instances). It matches each request against four base/size regions, forwards it with a region-relative offset address, and returns the selected slave's response. Unmapped or misaligned requests are reported by a same-cycle `fault` and answered locally. Stuck slaves are terminated by a watchdog timeout.

---
 rtl/bus_decoder_pkg.sv | 42 ++++
 rtl/bus_region_match.sv | 27 ++
 rtl/bus_decoder.sv | 169 ++++++++++++++++
 tb/tb_bus_decoder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_decoder_pkg.sv
// Shared constants, FSM state type and access-size helper for the bus decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bus_decoder_pkg;

  localparam int XLEN        = 32;
  localparam int BUS_WIDTH   = 32;
  localparam int BUS_ACC_CNT = 3;
  localparam int ACC_W       = $clog2(BUS_ACC_CNT);

  // Access-size encodings carried on acc / s_acc.
  localparam logic [ACC_W-1:0] ACC_BYTE = ACC_W'(0);
  localparam logic [ACC_W-1:0] ACC_HALF = ACC_W'(1);
  localparam logic [ACC_W-1:0] ACC_WORD = ACC_W'(2);

  localparam int NSLV   = 4;
  localparam int SEL_W  = $clog2(NSLV);
  localparam int WDOG_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FWD,
    ST_ERR,
    ST_RESP
  } state_t;

  // True when the low address bits suit the access size. The unused fourth
  // acc encoding is always treated as misaligned.
  function automatic logic acc_aligned(input logic [ACC_W-1:0] acc_i,
                                       input logic [1:0]       lsb);
    logic ok;
    ok = 1'b0;
    case (acc_i)
      ACC_BYTE: ok = 1'b1;
      ACC_HALF: ok = ~lsb[0];
      ACC_WORD: ok = (lsb == 2'b00);
      default:  ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/bus_region_match.sv
// Matches an address against one base/size window and yields the window-relative offset.
// Latency: combinational.
// Backpressure: none; pure decode.
//
// Ports:
//   addr   - byte address from the arbitrated bus
//   hit    - addr lies inside [BASE, BASE+SIZE); always 0 when SIZE is 0
//   offset - addr - BASE (only meaningful when hit)
module bus_region_match
  import bus_decoder_pkg::*;
#(
  parameter logic [XLEN-1:0] BASE = 32'h0000_0000,
  parameter logic [XLEN-1:0] SIZE = 32'h0000_1000
) (
  input  logic [XLEN-1:0] addr,
  output logic            hit,
  output logic [XLEN-1:0] offset
);

  // SIZE is a power of two and BASE is SIZE-aligned, so the window test
  // reduces to comparing the bits above the size boundary.
  localparam logic [XLEN-1:0] MASK = ~(SIZE - XLEN'(1));

  assign hit    = (SIZE != '0) && ((addr & MASK) == BASE);
  assign offset = addr - BASE;

endmodule

// File: rtl/bus_decoder.sv
// Address decoder / response mux between the shared core bus and four slave ports.
// Latency: req -> s_req 1 cycle; s_resp -> resp 1 cycle; faulted req -> resp 1 cycle.
// Backpressure: none; one transaction in flight, a req arriving outside IDLE is dropped.
//
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   addr, w_rb, acc, wdata, req - request from the arbitrated bus
//   resp, rdata    - single-cycle response strobe and read data
//   fault          - combinational: req is unmapped or misaligned
//   timeout_flag   - sticky watchdog-expiry indicator, cleared by rst only
//   s_addr         - per-slave region-relative address (slot k at [k*XLEN +: XLEN])
//   s_w_rb, s_acc, s_wdata - registered request fields shared by all slaves
//   s_req          - one-hot single-cycle slave request
//   s_resp, s_rdata - slave response strobes and read data (slot k at [k*BUS_WIDTH +: BUS_WIDTH])
module bus_decoder
  import bus_decoder_pkg::*;
#(
  parameter logic [XLEN-1:0] BASE0   = 32'h0000_0000,
  parameter logic [XLEN-1:0] BASE1   = 32'h1000_0000,
  parameter logic [XLEN-1:0] BASE2   = 32'h2000_0000,
  parameter logic [XLEN-1:0] BASE3   = 32'h3000_0000,
  parameter logic [XLEN-1:0] SIZE0   = 32'h0000_1000,
  parameter logic [XLEN-1:0] SIZE1   = 32'h0000_1000,
  parameter logic [XLEN-1:0] SIZE2   = 32'h0000_1000,
  parameter logic [XLEN-1:0] SIZE3   = 32'h0000_1000,
  parameter int unsigned     TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [XLEN-1:0]           addr,
  input  logic                      w_rb,
  input  logic [ACC_W-1:0]          acc,
  input  logic [BUS_WIDTH-1:0]      wdata,
  input  logic                      req,
  output logic                      resp,
  output logic [BUS_WIDTH-1:0]      rdata,
  output logic                      fault,
  output logic                      timeout_flag,
  output logic [NSLV*XLEN-1:0]      s_addr,
  output logic                      s_w_rb,
  output logic [ACC_W-1:0]          s_acc,
  output logic [BUS_WIDTH-1:0]      s_wdata,
  output logic [NSLV-1:0]           s_req,
  input  logic [NSLV-1:0]           s_resp,
  input  logic [NSLV*BUS_WIDTH-1:0] s_rdata
);

  logic [NSLV-1:0]  hit;
  logic [XLEN-1:0]  offset [NSLV];
  logic [SEL_W-1:0] hit_idx;
  logic             any_hit;
  logic             aligned;

  state_t           state;
  logic [SEL_W-1:0] sel;
  logic [WDOG_W-1:0] wdog;

  // ------------------------------------------------------------------
  // Region decode
  // ------------------------------------------------------------------
  bus_region_match #(.BASE(BASE0), .SIZE(SIZE0)) u_match0 (
    .addr  (addr),
    .hit   (hit[0]),
    .offset(offset[0])
  );

  bus_region_match #(.BASE(BASE1), .SIZE(SIZE1)) u_match1 (
    .addr  (addr),
    .hit   (hit[1]),
    .offset(offset[1])
  );

  bus_region_match #(.BASE(BASE2), .SIZE(SIZE2)) u_match2 (
    .addr  (addr),
    .hit   (hit[2]),
    .offset(offset[2])
  );

  bus_region_match #(.BASE(BASE3), .SIZE(SIZE3)) u_match3 (
    .addr  (addr),
    .hit   (hit[3]),
    .offset(offset[3])
  );

  // Overlapping regions resolve to the lowest index: scan downwards so the
  // last assignment made is the smallest hitting k.
  always_comb begin
    hit_idx = '0;
    for (int k = NSLV - 1; k >= 0; k--) begin
      if (hit[k]) begin
        hit_idx = SEL_W'(k);
      end
    end
  end

  assign any_hit = |hit;
  assign aligned = acc_aligned(acc, addr[1:0]);

  // Evaluated regardless of state so the requester always sees a bad
  // address in the same cycle, even for a request that will be dropped.
  assign fault = req & (~any_hit | ~aligned);

  // ------------------------------------------------------------------
  // Transaction FSM with watchdog; all outputs registered
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      sel          <= '0;
      wdog         <= '0;
      resp         <= 1'b0;
      rdata        <= '0;
      timeout_flag <= 1'b0;
      s_addr       <= '0;
      s_w_rb       <= 1'b0;
      s_acc        <= '0;
      s_wdata      <= '0;
      s_req        <= '0;
    end else begin
      // Both strobes are single-cycle pulses.
      resp  <= 1'b0;
      s_req <= '0;

      case (state)
        ST_IDLE: begin
          if (req) begin
            if (fault) begin
              state <= ST_ERR;
              resp  <= 1'b1;
              rdata <= '0;
            end else begin
              state                            <= ST_FWD;
              sel                              <= hit_idx;
              s_addr[hit_idx*XLEN +: XLEN]     <= offset[hit_idx];
              s_w_rb                           <= w_rb;
              s_acc                            <= acc;
              s_wdata                          <= wdata;
              s_req                            <= NSLV'(1) << hit_idx;
              wdog                             <= WDOG_W'(TIMEOUT);
            end
          end
        end

        ST_FWD: begin
          // The slave response is checked first so that an answer landing on
          // the expiry cycle still returns data and leaves the flag clear.
          if (s_resp[sel]) begin
            state <= ST_RESP;
            resp  <= 1'b1;
            rdata <= s_rdata[sel*BUS_WIDTH +: BUS_WIDTH];
          end else if (wdog == '0) begin
            state        <= ST_RESP;
            resp         <= 1'b1;
            rdata        <= '0;
            timeout_flag <= 1'b1;
          end else begin
            wdog <= wdog - WDOG_W'(1);
          end
        end

        // resp is already high for this cycle; just return to IDLE.
        ST_ERR:  state <= ST_IDLE;
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_decoder.sv
// Self-checking bench for bus_decoder: directed scenarios plus randomized traffic
// against a range/alignment reference model.
module tb_bus_decoder;

  localparam int TO = 8;

  logic         clk;
  logic         rst;
  logic [31:0]  addr;
  logic         w_rb;
  logic [1:0]   acc;
  logic [31:0]  wdata;
  logic         req;
  logic         resp;
  logic [31:0]  rdata;
  logic         fault;
  logic         timeout_flag;
  logic [127:0] s_addr;
  logic         s_w_rb;
  logic [1:0]   s_acc;
  logic [31:0]  s_wdata;
  logic [3:0]   s_req;
  logic [3:0]   s_resp;
  logic [127:0] s_rdata;

  int total = 0;
  int bad   = 0;

  localparam longint unsigned RB [4] = '{64'h0000_0000, 64'h1000_0000, 64'h2000_0000, 64'h3000_0000};
  localparam longint unsigned RS [4] = '{64'h1000, 64'h1000, 64'h1000, 64'h1000};

  bus_decoder #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .addr(addr), .w_rb(w_rb), .acc(acc), .wdata(wdata),
    .req(req), .resp(resp), .rdata(rdata), .fault(fault), .timeout_flag(timeout_flag),
    .s_addr(s_addr), .s_w_rb(s_w_rb), .s_acc(s_acc), .s_wdata(s_wdata),
    .s_req(s_req), .s_resp(s_resp), .s_rdata(s_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference decode: range containment and modulo alignment, lowest region wins.
  function automatic void ref_decode(input logic [31:0] a, input logic [1:0] ac,
                                     output bit flt, output int k, output logic [31:0] off);
    bit al;
    k = -1;
    off = '0;
    for (int i = 0; i < 4; i++) begin
      if (k < 0 && RS[i] != 0 && longint'(a) >= RB[i] && longint'(a) < RB[i] + RS[i]) k = i;
    end
    if (ac == 2'd3) al = 1'b0;
    else al = ((a % (32'd1 << ac)) == 0);
    flt = (k < 0) || !al;
    if (k >= 0) off = a - 32'(RB[k]);
  endfunction

  task automatic test_reset;
    rst = 1; req = 0; s_resp = '0; s_rdata = '0; addr = '0; w_rb = 0; acc = '0; wdata = '0;
    tick; tick;
    rst = 0;
    #1;
    total++; if (resp !== 1'b0) begin bad++; $display("FAIL reset_resp: got %b want 0", resp); end
    total++; if (s_req !== 4'b0) begin bad++; $display("FAIL reset_s_req: got %b want 0000", s_req); end
    total++; if (timeout_flag !== 1'b0) begin bad++; $display("FAIL reset_tflag: got %b want 0", timeout_flag); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    total++; if (s_addr !== 128'h0) begin bad++; $display("FAIL reset_s_addr: got %h want 0", s_addr); end
    total++; if ({s_w_rb, s_acc, s_wdata} !== 35'h0) begin bad++; $display("FAIL reset_s_fields: got %h want 0", {s_w_rb, s_acc, s_wdata}); end
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL reset_fault: got %b want 0", fault); end
  endtask

  task automatic test_read_word;
    tick;
    addr = 32'h1000_0010; w_rb = 0; acc = 2'd2; req = 1;
    #1;
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL rd_fault: got %b want 0", fault); end
    tick; req = 0;
    total++; if (s_req !== 4'b0010) begin bad++; $display("FAIL rd_s_req: got %b want 0010", s_req); end
    total++; if (s_addr[63:32] !== 32'h10) begin bad++; $display("FAIL rd_s_addr: got %h want 10", s_addr[63:32]); end
    total++; if (s_acc !== 2'd2 || s_w_rb !== 1'b0) begin bad++; $display("FAIL rd_s_fields: got acc=%0d w_rb=%b want 2/0", s_acc, s_w_rb); end
    tick;
    total++; if (s_req !== 4'b0 || resp !== 1'b0) begin bad++; $display("FAIL rd_idle_gap: got s_req=%b resp=%b want 0000/0", s_req, resp); end
    s_resp = 4'b0010; s_rdata[63:32] = 32'hDEAD_BEEF;
    tick; s_resp = '0;
    total++; if (resp !== 1'b1 || rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd_resp: got resp=%b rdata=%h want 1/deadbeef", resp, rdata); end
    tick;
    total++; if (resp !== 1'b0) begin bad++; $display("FAIL rd_resp_pulse: got %b want 0", resp); end
  endtask

  task automatic test_misaligned;
    tick;
    addr = 32'h2000_0003; w_rb = 1; acc = 2'd1; wdata = 32'h5555_AAAA; req = 1;
    #1;
    total++; if (fault !== 1'b1) begin bad++; $display("FAIL mis_fault: got %b want 1", fault); end
    tick; req = 0;
    total++; if (s_req !== 4'b0) begin bad++; $display("FAIL mis_s_req: got %b want 0000", s_req); end
    total++; if (resp !== 1'b1 || rdata !== 32'h0) begin bad++; $display("FAIL mis_resp: got resp=%b rdata=%h want 1/0", resp, rdata); end
    tick;
    total++; if (resp !== 1'b0 || s_req !== 4'b0) begin bad++; $display("FAIL mis_after: got resp=%b s_req=%b want 0/0000", resp, s_req); end
  endtask

  task automatic test_unmapped;
    tick;
    addr = 32'h4000_0000; w_rb = 0; acc = 2'd2; req = 1;
    #1;
    total++; if (fault !== 1'b1) begin bad++; $display("FAIL unm_fault: got %b want 1", fault); end
    tick; req = 0;
    total++; if (resp !== 1'b1 || rdata !== 32'h0 || s_req !== 4'b0) begin bad++; $display("FAIL unm_resp: got resp=%b rdata=%h s_req=%b want 1/0/0000", resp, rdata, s_req); end
  endtask

  task automatic test_timeout;
    int n;
    tick;
    addr = 32'h0000_0040; w_rb = 0; acc = 2'd2; req = 1;
    s_rdata[31:0] = 32'h7777_7777;
    tick; req = 0;
    total++; if (s_req !== 4'b0001) begin bad++; $display("FAIL to_s_req: got %b want 0001", s_req); end
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      tick; n = i;
      if (resp === 1'b1) break;
    end
    total++; if (resp !== 1'b1 || n != TO + 1) begin bad++; $display("FAIL to_latency: got %0d cycles (resp=%b) want %0d", n, resp, TO + 1); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL to_rdata: got %h want 0", rdata); end
    total++; if (timeout_flag !== 1'b1) begin bad++; $display("FAIL to_flag: got %b want 1", timeout_flag); end
    s_resp = 4'b0001; s_rdata[31:0] = 32'h0BAD_0BAD;
    tick;
    total++; if (resp !== 1'b0) begin bad++; $display("FAIL to_late1: got resp=%b want 0", resp); end
    tick; s_resp = '0;
    total++; if (resp !== 1'b0) begin bad++; $display("FAIL to_late2: got resp=%b want 0", resp); end
    total++; if (timeout_flag !== 1'b1) begin bad++; $display("FAIL to_sticky: got %b want 1", timeout_flag); end
  endtask

  task automatic test_drop_and_reset;
    tick;
    addr = 32'h2000_0100; w_rb = 0; acc = 2'd2; req = 1;
    tick;
    total++; if (s_req !== 4'b0100) begin bad++; $display("FAIL drop_s_req: got %b want 0100", s_req); end
    addr = 32'h3000_0000; req = 1;
    tick; req = 0;
    total++; if (s_req !== 4'b0000) begin bad++; $display("FAIL drop_extra_s_req: got %b want 0000", s_req); end
    s_resp = 4'b0100; s_rdata[95:64] = 32'hCAFE_F00D;
    tick; s_resp = '0;
    total++; if (resp !== 1'b1 || rdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL drop_resp: got resp=%b rdata=%h want 1/cafef00d", resp, rdata); end
    tick;
    total++; if (resp !== 1'b0 || s_req !== 4'b0) begin bad++; $display("FAIL drop_no_extra: got resp=%b s_req=%b want 0/0000", resp, s_req); end
    addr = 32'h3000_0004; w_rb = 1; acc = 2'd2; wdata = 32'h1357_9BDF; req = 1;
    tick; req = 0;
    total++; if (s_req !== 4'b1000) begin bad++; $display("FAIL rst_s_req: got %b want 1000", s_req); end
    rst = 1; s_resp = 4'b1000; s_rdata[127:96] = 32'hFEED_FACE;
    tick; rst = 0; s_resp = '0;
    total++; if (resp !== 1'b0 || s_req !== 4'b0 || rdata !== 32'h0 || timeout_flag !== 1'b0) begin bad++; $display("FAIL rst_outputs: got resp=%b s_req=%b rdata=%h tflag=%b want 0/0000/0/0", resp, s_req, rdata, timeout_flag); end
    total++; if (s_addr !== 128'h0 || {s_w_rb, s_acc, s_wdata} !== 35'h0) begin bad++; $display("FAIL rst_s_fields: got s_addr=%h fields=%h want 0/0", s_addr, {s_w_rb, s_acc, s_wdata}); end
    tick;
    total++; if (resp !== 1'b0) begin bad++; $display("FAIL rst_no_resp1: got %b want 0", resp); end
    tick;
    total++; if (resp !== 1'b0) begin bad++; $display("FAIL rst_no_resp2: got %b want 0", resp); end
  endtask

  task automatic test_simultaneous;
    tick;
    addr = 32'h0000_0008; w_rb = 0; acc = 2'd2; req = 1;
    tick; req = 0;
    total++; if (s_req !== 4'b0001) begin bad++; $display("FAIL sim_s_req: got %b want 0001", s_req); end
    for (int i = 0; i < TO; i++) tick;
    total++; if (resp !== 1'b0) begin bad++; $display("FAIL sim_early: got resp=%b want 0", resp); end
    s_resp = 4'b0001; s_rdata[31:0] = 32'h1234_5678;
    tick; s_resp = '0;
    total++; if (resp !== 1'b1 || rdata !== 32'h1234_5678) begin bad++; $display("FAIL sim_resp: got resp=%b rdata=%h want 1/12345678", resp, rdata); end
    total++; if (timeout_flag !== 1'b0) begin bad++; $display("FAIL sim_flag: got %b want 0", timeout_flag); end
  endtask

  // Random traffic; each new request is issued in the cycle right after the
  // previous resp, so back-to-back acceptance is exercised throughout.
  task automatic test_back_to_back_random;
    bit          flt;
    int          k, d, lat, exp_lat;
    logic [31:0] off, a, dat, exp_dat;
    logic [3:0]  noise;
    bit          exp_tflag;
    exp_tflag = 1'b0;
    for (int t = 0; t < 60; t++) begin
      int r;
      r = $urandom_range(0, 5);
      if (r < 4) a = 32'(RB[r]) + $urandom_range(0, 32'(RS[r]) - 1);
      else if (r == 4) a = 32'h4000_0000 + $urandom_range(0, 32'hFFFF);
      else a = 32'(RB[$urandom_range(0, 3)] + 64'h1000) - 32'($urandom_range(0, 1)) * 4;
      acc = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) != 0) a = a & ~32'h3;
      ref_decode(a, acc, flt, k, off);
      tick;
      addr = a; w_rb = 1'($urandom); wdata = $urandom; req = 1;
      #1;
      total++; if (fault !== flt) begin bad++; $display("FAIL rnd_fault[%0d]: addr=%h acc=%0d got %b want %b", t, a, acc, fault, flt); end
      if (flt) begin
        tick; req = 0;
        total++; if (resp !== 1'b1 || rdata !== 32'h0 || s_req !== 4'b0) begin bad++; $display("FAIL rnd_err[%0d]: got resp=%b rdata=%h s_req=%b want 1/0/0000", t, resp, rdata, s_req); end
      end else begin
        tick; req = 0;
        total++; if (s_req !== (4'b1 << k) || s_addr[k*32 +: 32] !== off) begin bad++; $display("FAIL rnd_fwd[%0d]: got s_req=%b off=%h want %b/%h", t, s_req, s_addr[k*32 +: 32], 4'b1 << k, off); end
        total++; if (s_w_rb !== w_rb || s_acc !== acc || s_wdata !== wdata) begin bad++; $display("FAIL rnd_fields[%0d]: got %b/%0d/%h want %b/%0d/%h", t, s_w_rb, s_acc, s_wdata, w_rb, acc, wdata); end
        d = $urandom_range(0, 11);
        dat = $urandom;
        exp_lat = (d <= TO) ? d + 1 : TO + 1;
        exp_dat = (d <= TO) ? dat : 32'h0;
        if (d > TO) exp_tflag = 1'b1;
        lat = 0;
        for (int c = 0; c <= 20; c++) begin
          noise = 4'($urandom);
          noise[k] = (c == d);
          s_resp = noise;
          s_rdata = {$urandom, $urandom, $urandom, $urandom};
          s_rdata[k*32 +: 32] = dat;
          tick; lat = c + 1;
          if (resp === 1'b1) break;
        end
        s_resp = '0;
        total++; if (resp !== 1'b1 || lat != exp_lat) begin bad++; $display("FAIL rnd_lat[%0d]: got %0d (resp=%b) want %0d", t, lat, resp, exp_lat); end
        total++; if (rdata !== exp_dat || timeout_flag !== exp_tflag) begin bad++; $display("FAIL rnd_data[%0d]: got %h/%b want %h/%b", t, rdata, timeout_flag, exp_dat, exp_tflag); end
      end
    end
    tick;
    total++; if (resp !== 1'b0) begin bad++; $display("FAIL rnd_final_idle: got resp=%b want 0", resp); end
  endtask

  initial begin
    clk = 0;
    test_reset;
    test_read_word;
    test_misaligned;
    test_unmapped;
    test_timeout;
    test_drop_and_reset;
    test_simultaneous;
    test_back_to_back_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
